// File: rtl/alu_share_arbiter.sv
// Two-client arbiter in front of a shared combinational ALU: round-robin grant,
// operand capture, ALU_LAT settle window, registered response. Optional ALU_ARB_STATS_EN adds grant counters.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      stat_ops0,
  output logic [15:0]      stat_ops1,
`endif
  output logic             busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t        r_state;
  logic          r_ptr;
  logic          r_id;
  logic [CW-1:0] r_cnt;
  logic          w_gnt0;
  logic          w_gnt1;

  // r_ptr == 0 gives req0 priority on a tie; it flips to the loser after each grant.
  assign w_gnt0 = (r_state == S_IDLE) && !rst && req0_valid && (!req1_valid || !r_ptr);
  assign w_gnt1 = (r_state == S_IDLE) && !rst && req1_valid && (!req0_valid ||  r_ptr);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            alu_op  <= w_gnt1 ? req1_op : req0_op;
            alu_a   <= w_gnt1 ? req1_a  : req0_a;
            alu_b   <= w_gnt1 ? req1_b  : req0_b;
            r_id    <= w_gnt1;
            r_ptr   <= w_gnt0;
            r_cnt   <= CW'(ALU_LAT - 1);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_id     <= r_id;
            rsp_valid  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops0 <= '0;
      stat_ops1 <= '0;
    end else begin
      if (w_gnt0 && (stat_ops0 != '1)) stat_ops0 <= stat_ops0 + 16'd1;
      if (w_gnt1 && (stat_ops1 != '1)) stat_ops1 <= stat_ops1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
// Define ALU_ARB_STATS_EN for both files to exercise the grant counters.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_id, rsp_zero, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_op;
  logic             alu_zero, busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      stat_ops0, stat_ops1;
`endif

  int tests = 0;
  int fails = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ready(rsp_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
`ifdef ALU_ARB_STATS_EN
    .stat_ops0(stat_ops0), .stat_ops1(stat_ops1),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_b - alu_a;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = ~alu_a & alu_b;
      3'b110: alu_result = alu_a ^ alu_b;
      default: alu_result = ~(alu_a ^ alu_b);
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction from a single requester with rsp_ready high.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero, input string tag);
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    chk({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_op"}, alu_op, op);
    chk({tag, "_early_valid"}, rsp_valid, 0);
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, id);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_zero"}, rsp_zero, exp_zero);
    tick();
    chk({tag, "_rsp_clear"}, rsp_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  int  g_n;
  int  g_cyc [4];
  logic g_id [4];

  initial begin
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst = 0;
    #1;
    chk("idle_ready0", req0_ready, 0);
    chk("idle_ready1", req1_ready, 0);

    // T1/T2: single-requester operations
    run_op(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, "t1_add");
    run_op(1'b1, 3'b001, 32'd9, 32'd9, 32'd0, 1'b1, "t2_sub");
    run_op(1'b1, 3'b010, 32'd3, 32'd10, 32'd7, 1'b0, "t2_rsub");
    chk("t2_alu_kept", alu_b, 32'd10);
    run_op(1'b0, 3'b111, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, "xnor_zero");
    run_op(1'b0, 3'b101, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b0, "andn_full");

    // T3: both valid from reset, round-robin 0,1,0,1 at one grant per 3 cycles
    rst = 1; tick(); tick(); rst = 0;
    req0_valid = 1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_op = 3'b110; req1_a = 32'd6; req1_b = 32'd3;
    #1;
    g_n = 0;
    for (int i = 0; i < 11; i++) begin
      if (req0_ready && req1_ready) chk("t3_double_grant", 1, 0);
      if ((req0_ready || req1_ready) && g_n < 4) begin
        g_cyc[g_n] = i; g_id[g_n] = req1_ready; g_n++;
      end
      if (i == 2) begin
        chk("t3_rsp0_valid", rsp_valid, 1);
        chk("t3_rsp0_id", rsp_id, 0);
        chk("t3_rsp0_res", rsp_result, 32'd3);
      end
      if (i == 5) begin
        chk("t3_rsp1_id", rsp_id, 1);
        chk("t3_rsp1_res", rsp_result, 32'd5);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("t3_grants", g_n, 4);
    chk("t3_g0_id", g_id[0], 0); chk("t3_g0_cyc", g_cyc[0], 0);
    chk("t3_g1_id", g_id[1], 1); chk("t3_g1_cyc", g_cyc[1], 3);
    chk("t3_g2_id", g_id[2], 0); chk("t3_g2_cyc", g_cyc[2], 6);
    chk("t3_g3_id", g_id[3], 1); chk("t3_g3_cyc", g_cyc[3], 9);
    tick(); tick();
    chk("t3_drained", busy, 0);

    // T4: response stall holds outputs and blocks new grants
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'b110; req0_a = 32'hF0; req0_b = 32'h0F;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_op = 3'b100; req1_a = 32'hFF; req1_b = 32'h0F;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", rsp_valid, 1);
      chk("t4_result", rsp_result, 32'hFF);
      chk("t4_busy", busy, 1);
      chk("t4_no_ready", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("t4_release", rsp_valid, 0);
    chk("t4_next_grant", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("t4_r1_id", rsp_id, 1);
    chk("t4_r1_res", rsp_result, 32'h0F);
    tick();

    // T5: reset during EXEC discards the op and restores req0 tie priority
    req0_valid = 1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    chk("t5_accept", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("t5_in_exec", busy, 1);
    rst = 1;
    tick();
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_rsp_result", rsp_result, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rsp", rsp_valid, 0);
    end
    req0_valid = 1; req0_op = 3'b000; req0_a = 32'd2;  req0_b = 32'd3;
    req1_valid = 1; req1_op = 3'b000; req1_a = 32'd10; req1_b = 32'd20;
    #1;
    chk("t5_tie_ready0", req0_ready, 1);
    chk("t5_tie_ready1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_rsp_res", rsp_result, 32'd5);
    tick();

`ifdef ALU_ARB_STATS_EN
    // T6: grant counters (one req0 grant already since the T5 reset)
    run_op(1'b0, 3'b011, 32'h1, 32'h2, 32'h3, 1'b0, "t6_a");
    run_op(1'b0, 3'b011, 32'h4, 32'h8, 32'hC, 1'b0, "t6_b");
    run_op(1'b1, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, "t6_c");
    chk("t6_ops0", stat_ops0, 3);
    chk("t6_ops1", stat_ops1, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_ops0_rst", stat_ops0, 0);
    chk("t6_ops1_rst", stat_ops1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
